sc_backg_scroll_ctrl: RTL and testbench

SC_BACKG_SCROLL_CTRL -- requirements
Module: sc_backg_scroll_ctrl

---
 rtl/sc_backg_scroll_ctrl_if.sv | 29 ++
 rtl/sc_backg_scroll_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sc_backg_scroll_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_backg_scroll_ctrl_if.sv
// Handshake bundle between the game controller and the background scroll sequencer.
interface sc_backg_scroll_ctrl_if #(
   parameter int unsigned NUM_ROWS = 8
);
   logic                start_InLow;
   logic                tick_In;
   logic                direction_In;
   logic                pause_InLow;
   logic                level_up_InLow;
   logic                clear_OutLow;
   logic                load_OutLow;
   logic [NUM_ROWS-1:0] rowsel_Out;
   logic [1:0]          shiftselection_Out;
   logic                transition_Out;
   logic [1:0]          level_Out;
   logic                busy_Out;

   modport master (
      output start_InLow, tick_In, direction_In, pause_InLow, level_up_InLow,
      input  clear_OutLow, load_OutLow, rowsel_Out, shiftselection_Out, transition_Out,
      input  level_Out, busy_Out
   );

   modport slave (
      input  start_InLow, tick_In, direction_In, pause_InLow, level_up_InLow,
      output clear_OutLow, load_OutLow, rowsel_Out, shiftselection_Out, transition_Out,
      output level_Out, busy_Out
   );
endinterface

// File: rtl/sc_backg_scroll_ctrl.sv
// Background row-register sequencer: clear, load rows, periodic rotate, level transitions.
// Optional macro BACKG_AUTO_LEVEL_EN advances the level automatically every 16 shifts.
module sc_backg_scroll_ctrl #(
   parameter int unsigned NUM_ROWS     = 8,
   parameter int unsigned SHIFT_PERIOD = 4,
   parameter int unsigned LEVEL_MAX    = 3
) (
   input logic                   SC_RegBACKGTYPE_CLOCK_50,
   input logic                   SC_RegBACKGTYPE_RESET_InHigh,
   sc_backg_scroll_ctrl_if.slave bus
);

   localparam int unsigned RowW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam logic [RowW-1:0] RowLast   = RowW'(NUM_ROWS - 1);
   localparam logic [7:0]      PerReload = 8'(SHIFT_PERIOD - 1);
   localparam logic [1:0]      LevelLast = 2'(LEVEL_MAX);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StClear = 3'd1;
   localparam logic [2:0] StLoad  = 3'd2;
   localparam logic [2:0] StRun   = 3'd3;
   localparam logic [2:0] StTrans = 3'd4;

   logic [2:0]          state_q, state_d;
   logic [RowW-1:0]     row_cnt_q, row_cnt_d;
   logic [7:0]          per_cnt_q, per_cnt_d;
   logic [1:0]          level_q, level_d;
   logic                clear_q, clear_d;
   logic                load_q, load_d;
   logic [NUM_ROWS-1:0] rowsel_q, rowsel_d;
   logic [1:0]          shift_sel_q, shift_sel_d;
   logic                trans_q, trans_d;
   logic                busy_q, busy_d;
   logic                shift_due;
   logic                level_req;

`ifdef BACKG_AUTO_LEVEL_EN
   logic [3:0] shift_cnt_q, shift_cnt_d;
   logic       auto_q, auto_d;

   // auto_q pulses the cycle after the 16th shift and is consumed by RUN as a level request.
   assign level_req = !bus.level_up_InLow || auto_q;
`else
   assign level_req = !bus.level_up_InLow;
`endif

   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      per_cnt_d = per_cnt_q;
      level_d   = level_q;
      shift_due = 1'b0;
      case (state_q)
         StIdle: begin
            if (!bus.start_InLow) state_d = StClear;
         end
         StClear: begin
            row_cnt_d = '0;
            state_d   = StLoad;
         end
         StLoad: begin
            if (row_cnt_q == RowLast) begin
               state_d   = StRun;
               per_cnt_d = PerReload;
            end else begin
               row_cnt_d = row_cnt_q + 1'b1;
            end
         end
         StRun: begin
            // A level request outranks a shift falling due on the same tick.
            if (level_req) begin
               state_d = StTrans;
            end else if (bus.pause_InLow && bus.tick_In) begin
               if (per_cnt_q == '0) begin
                  shift_due = 1'b1;
                  per_cnt_d = PerReload;
               end else begin
                  per_cnt_d = per_cnt_q - 8'd1;
               end
            end
         end
         StTrans: begin
            level_d = (level_q == LevelLast) ? 2'd0 : level_q + 2'd1;
            state_d = StClear;
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef BACKG_AUTO_LEVEL_EN
   always_comb begin
      shift_cnt_d = shift_cnt_q;
      auto_d      = shift_due && (shift_cnt_q == 4'hf);
      if (state_q == StClear) shift_cnt_d = 4'd0;
      else if (shift_due)     shift_cnt_d = shift_cnt_q + 4'd1;
   end

   always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
      if (SC_RegBACKGTYPE_RESET_InHigh) begin
         shift_cnt_q <= 4'd0;
         auto_q      <= 1'b0;
      end else begin
         shift_cnt_q <= shift_cnt_d;
         auto_q      <= auto_d;
      end
   end
`endif

   // Outputs are decoded from the next state so the registered copy lines up with state_q.
   always_comb begin
      clear_d     = (state_d != StClear);
      load_d      = (state_d != StLoad);
      trans_d     = (state_d == StTrans);
      busy_d      = (state_d != StIdle);
      shift_sel_d = 2'b00;
      if (shift_due) shift_sel_d = bus.direction_In ? 2'b10 : 2'b01;
      rowsel_d = '0;
      case (state_d)
         StClear, StTrans: rowsel_d = '1;
         StLoad:           rowsel_d = NUM_ROWS'(1) << row_cnt_d;
         StRun:            rowsel_d = shift_due ? '1 : '0;
         default:          rowsel_d = '0;
      endcase
   end

   always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
      if (SC_RegBACKGTYPE_RESET_InHigh) begin
         state_q     <= StIdle;
         row_cnt_q   <= '0;
         per_cnt_q   <= 8'd0;
         level_q     <= 2'd0;
         clear_q     <= 1'b1;
         load_q      <= 1'b1;
         rowsel_q    <= '0;
         shift_sel_q <= 2'b00;
         trans_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_cnt_q   <= row_cnt_d;
         per_cnt_q   <= per_cnt_d;
         level_q     <= level_d;
         clear_q     <= clear_d;
         load_q      <= load_d;
         rowsel_q    <= rowsel_d;
         shift_sel_q <= shift_sel_d;
         trans_q     <= trans_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.clear_OutLow       = clear_q;
   assign bus.load_OutLow        = load_q;
   assign bus.rowsel_Out         = rowsel_q;
   assign bus.shiftselection_Out = shift_sel_q;
   assign bus.transition_Out     = trans_q;
   assign bus.level_Out          = level_q;
   assign bus.busy_Out           = busy_q;

endmodule

// File: tb/tb_sc_backg_scroll_ctrl.sv
// Bench for sc_backg_scroll_ctrl: fixed vector table, directed corner sequences, random run.
module tb_sc_backg_scroll_ctrl;
   localparam int unsigned NR = 8;
   localparam int unsigned SP = 4;
   localparam int unsigned LM = 3;
   localparam int unsigned OW = NR + 8;

   localparam int PhIdle  = 0;
   localparam int PhSeq   = 1;
   localparam int PhRun   = 2;
   localparam int PhTrans = 3;

   typedef logic [OW-1:0] out_t;
   typedef struct {
      logic st;
      logic tk;
      logic dr;
      logic ps;
      logic lu;
      out_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sc_backg_scroll_ctrl_if #(.NUM_ROWS(NR)) bus ();

   sc_backg_scroll_ctrl #(
      .NUM_ROWS(NR),
      .SHIFT_PERIOD(SP),
      .LEVEL_MAX(LM)
   ) dut (
      .SC_RegBACKGTYPE_CLOCK_50(clk),
      .SC_RegBACKGTYPE_RESET_InHigh(rst),
      .bus(bus)
   );

   out_t act;
   assign act = {bus.clear_OutLow, bus.load_OutLow, bus.rowsel_Out, bus.shiftselection_Out,
                 bus.transition_Out, bus.level_Out, bus.busy_Out};

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: position in the reload sequence and a running count of live ticks.
   int   m_phase, m_seq, m_ticks, m_level;
   logic m_shift, m_dir;

   function automatic out_t mk(logic c, logic l, logic [NR-1:0] rs, logic [1:0] sh, logic tr,
                               logic [1:0] lv, logic b);
      return {c, l, rs, sh, tr, lv, b};
   endfunction

   function automatic vec_t mkv(logic st, logic tk, logic dr, logic ps, logic lu, out_t e);
      vec_t v;
      v.st = st; v.tk = tk; v.dr = dr; v.ps = ps; v.lu = lu; v.exp = e;
      return v;
   endfunction

   function automatic out_t model_out();
      logic [NR-1:0] rs;
      logic [1:0]    sh;
      rs = '0;
      if (m_phase == PhSeq && m_seq == 0)        rs = '1;
      else if (m_phase == PhSeq)                 rs = NR'(1) << (m_seq - 1);
      else if (m_phase == PhTrans)               rs = '1;
      else if (m_phase == PhRun && m_shift)      rs = '1;
      sh = m_shift ? (m_dir ? 2'b10 : 2'b01) : 2'b00;
      return mk(!(m_phase == PhSeq && m_seq == 0), !(m_phase == PhSeq && m_seq > 0), rs, sh,
                m_phase == PhTrans, 2'(m_level), m_phase != PhIdle);
   endfunction

   task automatic model_reset();
      m_phase = PhIdle; m_seq = 0; m_ticks = 0; m_level = 0; m_shift = 1'b0; m_dir = 1'b0;
   endtask

   task automatic model_step(input logic st, tk, dr, ps, lu);
      m_shift = 1'b0;
      m_dir   = dr;
      case (m_phase)
         PhIdle:  if (!st) begin m_phase = PhSeq; m_seq = 0; end
         PhSeq: begin
            if (m_seq == NR) begin m_phase = PhRun; m_ticks = 0; end
            else m_seq++;
         end
         PhRun: begin
            if (!lu) m_phase = PhTrans;
            else if (ps && tk) begin
               m_ticks++;
               if (m_ticks % SP == 0) m_shift = 1'b1;
            end
         end
         default: begin
            m_level = (m_level + 1) % (LM + 1);
            m_phase = PhSeq;
            m_seq   = 0;
         end
      endcase
   endtask

   task automatic check(input string name, input out_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check2(input string name, input logic [1:0] a, input logic [1:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %b want %b (t=%0t)", name, a, e, $time);
      end
   endtask

   task automatic drive(input logic st, tk, dr, ps, lu);
      bus.start_InLow    = st;
      bus.tick_In        = tk;
      bus.direction_In   = dr;
      bus.pause_InLow    = ps;
      bus.level_up_InLow = lu;
   endtask

   task automatic step(input logic st, tk, dr, ps, lu, input string name);
      drive(st, tk, dr, ps, lu);
      model_step(st, tk, dr, ps, lu);
      @(posedge clk);
      #1;
      check(name, model_out());
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset", model_out());
   endtask

   task automatic async_reset_check(input string name);
      #2 rst = 1'b1;
      model_reset();
      #1 check(name, model_out());
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // From IDLE: start, clear, eight loads, first RUN cycle.
   task automatic enter_run(input string name);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, name);
      repeat (NR + 1) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, name);
   endtask

   // From TRANS: clear, eight loads, first RUN cycle.
   task automatic reload(input string name);
      repeat (NR + 2) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, name);
   endtask

   vec_t vt[19];

   initial begin
      logic [NR-1:0] rs_v;
      logic [1:0]    sh_v;

      vt[0] = mkv(1, 0, 0, 1, 1, mk(1, 1, '0, 2'b00, 0, 2'd0, 0));
      vt[1] = mkv(0, 0, 0, 1, 1, mk(0, 1, '1, 2'b00, 0, 2'd0, 1));
      for (int i = 0; i < 8; i++) begin
         rs_v = NR'(1) << i;
         vt[2 + i] = mkv(1, 0, 0, 1, 1, mk(1, 0, rs_v, 2'b00, 0, 2'd0, 1));
      end
      vt[10] = mkv(1, 0, 0, 1, 1, mk(1, 1, '0, 2'b00, 0, 2'd0, 1));
      for (int k = 1; k <= 8; k++) begin
         rs_v = (k % 4 == 0) ? '1 : '0;
         sh_v = (k % 4 == 0) ? 2'b01 : 2'b00;
         vt[10 + k] = mkv(1, 1, 0, 1, 1, mk(1, 1, rs_v, sh_v, 0, 2'd0, 1));
      end

      do_reset();
      for (int i = 0; i < 19; i++) begin
         drive(vt[i].st, vt[i].tk, vt[i].dr, vt[i].ps, vt[i].lu);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), vt[i].exp);
      end

      // Pause holds the count; the shift lands on the tick that completes it.
      do_reset();
      enter_run("pz_enter");
      step(1, 1, 0, 1, 1, "pz_t1");
      step(1, 1, 0, 1, 1, "pz_t2");
      repeat (6) step(1, 1, 0, 0, 1, "pz_hold");
      step(1, 0, 0, 0, 1, "pz_idle");
      step(1, 1, 0, 1, 1, "pz_t3");
      check2("pz_no_early", bus.shiftselection_Out, 2'b00);
      step(1, 1, 0, 1, 1, "pz_t4");
      check2("pz_resume_shift", bus.shiftselection_Out, 2'b01);

      // Walk to level 3, then a level request on the shift-due tick.
      do_reset();
      enter_run("lv_enter");
      for (int lv = 0; lv < 3; lv++) begin
         step(1, 0, 0, 1, 0, "lv_req");
         reload("lv_reload");
      end
      check2("lv_at_max", bus.level_Out, 2'd3);
      repeat (3) step(1, 1, 1, 1, 1, "co_tick");
      step(1, 1, 1, 1, 0, "co_req");
      check2("co_no_shift", bus.shiftselection_Out, 2'b00);
      check2("co_trans", {1'b0, bus.transition_Out}, 2'b01);
      step(1, 0, 0, 1, 1, "co_clear");
      check2("co_wrap", bus.level_Out, 2'd0);
      check2("co_clear_low", {1'b0, bus.clear_OutLow}, 2'b00);
      repeat (NR + 1) step(1, 0, 0, 1, 1, "co_reload");
      repeat (4) step(1, 1, 1, 1, 1, "rt_tick");
      check2("rt_dir_right", bus.shiftselection_Out, 2'b10);

      // Asynchronous reset mid-LOAD (row 4) and mid-TRANS.
      do_reset();
      enter_run("ml_enter");
      step(1, 0, 0, 1, 0, "ml_req");
      step(1, 0, 0, 1, 1, "ml_clear");
      repeat (5) step(1, 0, 0, 1, 1, "ml_load");
      check2("ml_row4", {1'b0, bus.rowsel_Out[4]}, 2'b01);
      async_reset_check("ml_rst");
      repeat (3) step(1, 1, 0, 1, 0, "ml_idle_hold");
      step(0, 0, 0, 1, 1, "ml_restart");
      repeat (NR + 1) step(1, 0, 0, 1, 1, "mt_load");
      step(1, 0, 0, 1, 0, "mt_req");
      async_reset_check("mt_rst");

      // Random traffic with occasional asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) async_reset_check("rand_rst");
         step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 4) != 0, $urandom_range(0, 39) != 0, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
